// File: rtl/disp_mode_ctrl.sv
// Display mode controller: watch / stopwatch / calibration selection driven by
// button pulses or single-letter UART commands, with a blinking cursor and an
// inactivity timeout while calibrating.
module disp_mode_ctrl #(
  parameter int unsigned BLINK_DIV     = 50_000_000,
  parameter int unsigned CALIB_TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_fmt,
  input  logic       btn_calib,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       stpw_mode,
  output logic       fmt_mode,
  output logic       calib_mode,
  output logic       calib_right,
  output logic       blink
);

  localparam int unsigned DivW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned ToW  = (CALIB_TIMEOUT > 1) ? $clog2(CALIB_TIMEOUT) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(BLINK_DIV - 1);
  localparam logic [ToW-1:0]  ToMax  = ToW'(CALIB_TIMEOUT - 1);

  typedef enum logic [1:0] {StWatch, StStpw, StCalib} state_e;
  typedef enum logic [2:0] {EvNone, EvMode, EvFmt, EvCalib, EvLeft, EvRight} event_e;

  state_e          state_q, state_d;
  event_e          ev;
  logic            buf_full_q, buf_full_d;
  logic [7:0]      buf_data_q, buf_data_d;
  logic            fmt_q, fmt_d;
  logic            right_q, right_d;
  logic            blink_q, blink_d;
  logic            stpw_q, calib_q;
  logic [DivW-1:0] div_q, div_d;
  logic [ToW-1:0]  to_q, to_d;
  logic            btn_any;
  logic            tick;
  logic            timeout;

  assign btn_any = btn_mode | btn_fmt | btn_calib | btn_left | btn_right;

  // Event arbitration: buttons first in fixed priority, buffered command only when idle.
  always_comb begin
    ev = EvNone;
    if (btn_calib)      ev = EvCalib;
    else if (btn_mode)  ev = EvMode;
    else if (btn_fmt)   ev = EvFmt;
    else if (btn_left)  ev = EvLeft;
    else if (btn_right) ev = EvRight;
    else if (buf_full_q) begin
      unique case (buf_data_q)
        8'h4D:   ev = EvMode;
        8'h46:   ev = EvFmt;
        8'h43:   ev = EvCalib;
        8'h4C:   ev = EvLeft;
        8'h52:   ev = EvRight;
        default: ev = EvNone;
      endcase
    end
  end

  // One-entry command buffer: drained in any cycle without a button pulse.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    if (buf_full_q && !btn_any) buf_full_d = 1'b0;
    if (rx_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_data_d = rx_data;
    end
  end

  // Next-state, format toggle, cursor, blink divider and inactivity timeout.
  always_comb begin
    state_d = state_q;
    fmt_d   = fmt_q;
    right_d = right_q;
    blink_d = blink_q;
    div_d   = div_q;
    to_d    = to_q;
    tick    = 1'b0;
    timeout = 1'b0;
    if (ev == EvFmt) fmt_d = ~fmt_q;
    case (state_q)
      StWatch: begin
        if (ev == EvMode) begin
          state_d = StStpw;
        end else if (ev == EvCalib) begin
          state_d = StCalib;
          right_d = 1'b0;
        end
      end
      StStpw: begin
        if (ev == EvMode) state_d = StWatch;
      end
      StCalib: begin
        if (div_q == DivMax) begin
          div_d   = '0;
          blink_d = ~blink_q;
          tick    = 1'b1;
        end else begin
          div_d = div_q + DivW'(1);
        end
        if (tick) begin
          if (to_q == ToMax) begin
            timeout = 1'b1;
            to_d    = '0;
          end else begin
            to_d = to_q + ToW'(1);
          end
        end
        // A real event always outranks a coincident timeout.
        if (ev != EvNone) to_d = '0;
        case (ev)
          EvCalib: state_d = StWatch;
          EvLeft:  right_d = 1'b0;
          EvRight: right_d = 1'b1;
          EvNone:  if (timeout) state_d = StWatch;
          default: ;
        endcase
      end
      default: state_d = StWatch;
    endcase
    // Calibration context does not survive leaving calibration.
    if (state_d != StCalib) begin
      blink_d = 1'b0;
      div_d   = '0;
      to_d    = '0;
    end
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StWatch;
      buf_full_q <= 1'b0;
      buf_data_q <= 8'h00;
      fmt_q      <= 1'b0;
      right_q    <= 1'b0;
      blink_q    <= 1'b0;
      stpw_q     <= 1'b0;
      calib_q    <= 1'b0;
      div_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      fmt_q      <= fmt_d;
      right_q    <= right_d;
      blink_q    <= blink_d;
      stpw_q     <= (state_d == StStpw);
      calib_q    <= (state_d == StCalib);
      div_q      <= div_d;
      to_q       <= to_d;
    end
  end

  assign rx_ready    = ~buf_full_q;
  assign stpw_mode   = stpw_q;
  assign fmt_mode    = fmt_q;
  assign calib_mode  = calib_q;
  assign calib_right = right_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Bench for disp_mode_ctrl: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the mode rules.
module tb_disp_mode_ctrl;

  localparam int unsigned BlinkDiv = 4;
  localparam int unsigned CalibTo  = 3;

  localparam int MWatch = 0;
  localparam int MStpw  = 1;
  localparam int MCalib = 2;

  // Button vector layout for step(): {calib, mode, fmt, left, right}
  localparam logic [4:0] BCalib = 5'b10000;
  localparam logic [4:0] BMode  = 5'b01000;
  localparam logic [4:0] BFmt   = 5'b00100;
  localparam logic [4:0] BNone  = 5'b00000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_fmt = 1'b0, btn_calib = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready, stpw_mode, fmt_mode, calib_mode, calib_right, blink;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_state;
  bit         m_fmt, m_right;
  int         m_age;   // cycles spent in calibration since entry
  int         m_tog;   // blink toggles since entry or last event
  logic [7:0] m_q[$];

  disp_mode_ctrl #(.BLINK_DIV(BlinkDiv), .CALIB_TIMEOUT(CalibTo)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_fmt(btn_fmt), .btn_calib(btn_calib),
    .btn_left(btn_left), .btn_right(btn_right),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .stpw_mode(stpw_mode), .fmt_mode(fmt_mode), .calib_mode(calib_mode),
    .calib_right(calib_right), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = MWatch;
    m_fmt   = 0;
    m_right = 0;
    m_age   = 0;
    m_tog   = 0;
    m_q.delete();
  endfunction

  // 0 none, 1 mode, 2 fmt, 3 calib, 4 left, 5 right
  function automatic int decode(input logic [7:0] b);
    case (b)
      "M": return 1;
      "F": return 2;
      "C": return 3;
      "L": return 4;
      "R": return 5;
      default: return 0;
    endcase
  endfunction

  function automatic void model_step(input logic [4:0] b, input logic v, input logic [7:0] d);
    int  ev;
    bit  ready;
    bit  timeout;
    ready = (m_q.size() == 0);
    ev = 0;
    if (b[4])      ev = 3;
    else if (b[3]) ev = 1;
    else if (b[2]) ev = 2;
    else if (b[1]) ev = 4;
    else if (b[0]) ev = 5;
    else if (m_q.size() != 0) ev = decode(m_q.pop_front());
    if (v && ready) m_q.push_back(d);
    if (ev == 2) m_fmt = !m_fmt;
    if (m_state == MWatch) begin
      if (ev == 1) m_state = MStpw;
      else if (ev == 3) begin
        m_state = MCalib;
        m_right = 0;
        m_age   = 0;
        m_tog   = 0;
      end
    end else if (m_state == MStpw) begin
      if (ev == 1) m_state = MWatch;
    end else begin
      m_age++;
      if (m_age % BlinkDiv == 0) m_tog++;
      timeout = (m_tog == CalibTo);
      if (ev != 0) m_tog = 0;
      if (ev == 3) m_state = MWatch;
      else if (ev == 4) m_right = 0;
      else if (ev == 5) m_right = 1;
      else if (ev == 0 && timeout) m_state = MWatch;
    end
  endfunction

  task automatic check_outputs();
    check("stpw_mode", stpw_mode, m_state == MStpw);
    check("calib_mode", calib_mode, m_state == MCalib);
    check("fmt_mode", fmt_mode, m_fmt);
    check("calib_right", calib_right, m_right);
    check("blink", blink, (m_state == MCalib) ? (m_age / BlinkDiv) % 2 : 0);
    check("rx_ready", rx_ready, m_q.size() == 0);
  endtask

  // One clock cycle: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input logic [4:0] b, input logic v, input logic [7:0] d);
    {btn_calib, btn_mode, btn_fmt, btn_left, btn_right} = b;
    rx_valid = v;
    rx_data  = d;
    model_step(b, v, d);
    @(posedge clk);
    #1;
    {btn_calib, btn_mode, btn_fmt, btn_left, btn_right} = 5'b0;
    rx_valid = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          fmt_before;
    logic [7:0]  bytes [6];
    logic [4:0]  b;
    bytes[0] = "M"; bytes[1] = "F"; bytes[2] = "C";
    bytes[3] = "L"; bytes[4] = "R"; bytes[5] = "A";

    model_reset();
    #12;
    check_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Mode button toggles stopwatch on and off
    step(BMode, 1'b0, 8'h00);
    check("mode_on", stpw_mode, 1'b1);
    step(BMode, 1'b0, 8'h00);
    check("mode_off", stpw_mode, 1'b0);

    // UART 'C' enters calibration two edges after acceptance, 'R' moves cursor
    step(BNone, 1'b1, 8'h43);
    check("uart_c_ready", rx_ready, 1'b0);
    check("uart_c_early", calib_mode, 1'b0);
    step(BNone, 1'b0, 8'h00);
    check("uart_c_calib", calib_mode, 1'b1);
    step(BNone, 1'b1, 8'h52);
    step(BNone, 1'b0, 8'h00);
    check("uart_r_right", calib_right, 1'b1);
    step(BCalib, 1'b0, 8'h00);

    // Button outranks buffered 'F'; the command is held one more cycle
    step(BNone, 1'b1, 8'h46);
    step(BMode, 1'b0, 8'h00);
    check("hold_stpw", stpw_mode, 1'b1);
    check("hold_fmt0", fmt_mode, 1'b0);
    step(BNone, 1'b0, 8'h00);
    check("hold_fmt1", fmt_mode, 1'b1);
    step(BMode, 1'b0, 8'h00);

    // Blink every BlinkDiv cycles, timeout after CalibTo toggles
    step(BCalib, 1'b0, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      step(BNone, 1'b0, 8'h00);
      if (k == 4)  check("blink_first", blink, 1'b1);
      if (k == 8)  check("blink_second", blink, 1'b0);
      if (k == 11) check("calib_held", calib_mode, 1'b1);
    end
    check("timeout_exit", calib_mode, 1'b0);
    check("timeout_blink", blink, 1'b0);

    // Coincident calib+fmt: calib wins, fmt dropped; unknown byte is discarded
    fmt_before = fmt_mode;
    step(BCalib | BFmt, 1'b0, 8'h00);
    check("prio_calib", calib_mode, 1'b1);
    check("prio_fmt", fmt_mode, fmt_before);
    step(BNone, 1'b1, 8'h41);
    step(BNone, 1'b0, 8'h00);
    check("junk_ready", rx_ready, 1'b1);
    check("junk_calib", calib_mode, 1'b1);

    // Reset during calibration with a full buffer
    step(BNone, 1'b1, 8'h4D);
    check("full_before_rst", rx_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_calib", calib_mode, 1'b0);
    check("rst_fmt", fmt_mode, 1'b0);
    check("rst_ready", rx_ready, 1'b1);
    check("rst_blink", blink, 1'b0);
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with busy and quiet phases so timeouts happen
    for (int i = 0; i < 3000; i++) begin
      bit quiet;
      quiet = ((i / 64) % 2) == 1;
      b = 5'b0;
      for (int j = 0; j < 5; j++)
        if ($urandom_range(0, quiet ? 60 : 9) == 0) b[j] = 1'b1;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step(b, $urandom_range(0, quiet ? 40 : 2) == 0,
             ($urandom_range(0, 7) == 0) ? 8'($urandom) : bytes[$urandom_range(0, 5)]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_mode_ctrl.md
DISP_MODE_CTRL -- requirements
Module: disp_mode_ctrl

Interface
REQ-001 Parameter BLINK_DIV, default 50_000_000: clk cycles per blink half-period.
REQ-002 Parameter CALIB_TIMEOUT, default 20: blink half-periods without an accepted event before calibration auto-exits.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 btn_mode, btn_fmt, btn_calib, btn_left, btn_right  in  1 each  debounced single-cycle button pulses.
REQ-006 rx_valid  in  1  UART received byte valid.
REQ-007 rx_data  in  8  UART received ASCII byte.
REQ-008 rx_ready  out  1  command buffer empty; byte accepted when rx_valid & rx_ready.
REQ-009 stpw_mode  out  1  1 = stopwatch shown/controlled, 0 = watch.
REQ-010 fmt_mode  out  1  1 = hour:min format, 0 = sec:msec format.
REQ-011 calib_mode  out  1  1 = watch time-setting active.
REQ-012 calib_right  out  1  calibration cursor: 1 = right field pair, 0 = left field pair.
REQ-013 blink  out  1  blank request for the field under the cursor; 0 outside calibration.

Function
REQ-014 FSM states SHALL be WATCH, STPW, CALIB; outputs registered; stpw_mode = (state==STPW), calib_mode = (state==CALIB).
REQ-015 Events SHALL be MODE, FMT, CALIB, LEFT, RIGHT, sourced from the buttons or the UART command buffer.
REQ-016 UART decode SHALL be: 0x4D 'M'=MODE, 0x46 'F'=FMT, 0x43 'C'=CALIB, 0x4C 'L'=LEFT, 0x52 'R'=RIGHT; any other accepted byte SHALL be discarded with no effect.
REQ-017 The one-entry buffer SHALL capture a byte on rx_valid & rx_ready; rx_ready = 0 while the buffer is full.
REQ-018 Button pulses SHALL take priority; the buffered command is applied only in a cycle with no button pulse and is held otherwise.
REQ-019 If several button pulses coincide, priority SHALL be CALIB > MODE > FMT > LEFT > RIGHT; only one event applies per cycle and lower-priority pulses are dropped.
REQ-020 Latency: a button pulse in cycle N SHALL update outputs at edge N+1; a UART byte accepted in cycle N SHALL apply at edge N+2 if no button pulse occurs in cycle N+1.
REQ-021 WATCH: MODE -> STPW; CALIB -> CALIB with calib_right=0; LEFT and RIGHT ignored.
REQ-022 STPW: MODE -> WATCH; CALIB, LEFT and RIGHT ignored.
REQ-023 CALIB: CALIB -> WATCH; LEFT -> calib_right=0; RIGHT -> calib_right=1; MODE ignored.
REQ-024 FMT SHALL toggle fmt_mode in every state and SHALL NOT change state.
REQ-025 In CALIB, a 0..BLINK_DIV-1 divider SHALL toggle blink on wrap; blink SHALL start at 0 on entry, and blink and the divider SHALL clear on exit.
REQ-026 In CALIB, a timeout counter SHALL increment on each blink toggle and SHALL clear on any applied event; on reaching CALIB_TIMEOUT the FSM SHALL go to WATCH at that edge.
REQ-027 An applied event and timeout in the same cycle: the event wins and the timeout counter clears.
REQ-028 Divider and timeout counter widths SHALL be $clog2 of their parameter; no overflow (wrap at terminal value).

Reset
REQ-029 On rst=0, asynchronously: state=WATCH, stpw_mode=0, fmt_mode=0, calib_mode=0, calib_right=0, blink=0, buffer empty (rx_ready=1), all counters 0.
REQ-030 Reset asserted mid-calibration or with a full buffer SHALL discard the pending command and the calibration context.

Verification
REQ-031 btn_mode pulse from reset -> next edge stpw_mode=1; second pulse -> stpw_mode=0.
REQ-032 rx_valid with 0x43, no buttons -> rx_ready=0 one cycle later, calib_mode=1 two edges after accept; then 0x52 -> calib_right=1.
REQ-033 rx byte 0x46 accepted, btn_mode pulse in the following cycle -> stpw_mode=1 first, fmt_mode=1 one edge later.
REQ-034 BLINK_DIV=4, CALIB_TIMEOUT=3, enter CALIB, no events -> blink toggles every 4 cycles; exit to WATCH after 12 cycles with blink=0.
REQ-035 btn_calib and btn_fmt pulsed together in WATCH -> calib_mode=1, fmt_mode unchanged; 0x41 byte -> no output change, rx_ready back to 1.
REQ-036 rst low during CALIB with a full buffer -> all outputs at reset values immediately, rx_ready=1.
